// File: rtl/scu_pkg.sv
// scu_pkg: shared types, lane-config layout and field offsets for the signal control unit
package scu_pkg;
  typedef enum logic [1:0] {PASS, FORCE0, FORCE1, INVERT} action_e;
  typedef enum logic [1:0] {IDLE, LEVEL, HOLD} lane_state_e;
  localparam int M_DEF = 6;
  localparam int D_DEF = 8;
  localparam int OFF_EN = 0;
  localparam int OFF_ACT = 1;
  localparam int OFF_SEL = 3;
  function automatic int sel_w(input int m);
    return $clog2(m);
  endfunction
  function automatic int off_hold(input int m);
    return OFF_SEL + sel_w(m);
  endfunction
  function automatic int cfg_w(input int m, input int d);
    return off_hold(m) + d;
  endfunction
  typedef struct packed {
    logic [D_DEF-1:0]           hold;
    logic [sel_w(M_DEF)-1:0]    sel;
    action_e                    action;
    logic                       en;
  } lane_cfg_t;
endpackage

// File: rtl/scu_lane.sv
// scu_lane: one controllable lane, trigger-driven FSM with hold counter and output patch mux
module scu_lane import scu_pkg::*; #(
  parameter int M = M_DEF,
  parameter int D = D_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic                en,
  input  action_e             action,
  input  logic [sel_w(M)-1:0] sel,
  input  logic [D-1:0]        hold,
  input  logic [M-1:0]        trigger,
  input  logic                s_in,
  output logic                s_out,
  output logic                patch_active
);
  localparam int SW = sel_w(M);
  localparam int TW = 2 ** SW;
  lane_state_e state_q, state_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic [TW-1:0] trig_x;
  logic t;
  // zero-extended so out-of-range selects read as an inactive trigger
  assign trig_x = TW'(trigger);
  assign t = en & trig_x[sel];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (cfg_en) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (t) begin
          state_d = (hold == '0) ? LEVEL : HOLD;
          cnt_d = hold;
        end
        LEVEL: if (!t) state_d = IDLE;
        HOLD: if (t) cnt_d = hold;
          else if (cnt_q == D'(1)) begin
            state_d = IDLE;
            cnt_d = '0;
          end else cnt_d = cnt_q - 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign patch_active = !cfg_en && state_q != IDLE;
  assign s_out = !patch_active ? s_in :
                 action == FORCE0 ? 1'b0 :
                 action == FORCE1 ? 1'b1 :
                 action == INVERT ? ~s_in : s_in;
endmodule

// File: rtl/scu.sv
// scu: signal control unit, serial config scan chain feeding L independently triggered patch lanes
module scu import scu_pkg::*; #(
  parameter int M = M_DEF,
  parameter int L = 4,
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] trigger,
  input  logic [L-1:0] s_in,
  output logic [L-1:0] s_out,
  output logic [L-1:0] patch_active,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out
);
  localparam int W = cfg_w(M, D);
  localparam int SW = sel_w(M);
  localparam int OH = off_hold(M);
  localparam int N = L * W;
  logic [N-1:0] chain_q, chain_d;
  assign chain_d = cfg_en ? {cfg_in, chain_q[N-1:1]} : chain_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain_q <= '0;
    else chain_q <= chain_d;
  end
  // chain_q[0] is itself a flop, so each SCU adds exactly N stages to a daisy chain
  assign cfg_out = chain_q[0];
  for (genvar g = 0; g < L; g++) begin : g_lane
    logic [W-1:0] c;
    assign c = chain_q[g*W +: W];
    scu_lane #(.M(M), .D(D)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .cfg_en       (cfg_en),
      .en           (c[OFF_EN]),
      .action       (action_e'(c[OFF_ACT +: 2])),
      .sel          (c[OFF_SEL +: SW]),
      .hold         (c[OH +: D]),
      .trigger      (trigger),
      .s_in         (s_in[g]),
      .s_out        (s_out[g]),
      .patch_active (patch_active[g])
    );
  end
endmodule

// File: tb/tb_scu.sv
// tb_scu: directed self-checking bench for scu (M=6, L=4, D=8, 56-bit chain)
module tb_scu;
  import scu_pkg::*;
  logic clk = 0;
  logic rst = 0;
  logic [5:0] trigger = '0;
  logic [3:0] s_in = '0;
  logic [3:0] s_out, patch_active;
  logic cfg_en = 0;
  logic cfg_in = 0;
  logic cfg_out;
  int errors = 0;
  int checks = 0;
  localparam lane_cfg_t Z = '0;
  localparam lane_cfg_t INV5 = '{hold: 8'd5, sel: 3'd0, action: INVERT, en: 1'b1};
  scu #(.M(6), .L(4), .D(8)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .s_in(s_in), .s_out(s_out),
    .patch_active(patch_active), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out)
  );
  always #5 clk = ~clk;
  function automatic logic [55:0] mk(input lane_cfg_t a, input lane_cfg_t b, input lane_cfg_t c, input lane_cfg_t d);
    return {d, c, b, a};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic shift(input logic [55:0] v);
    cfg_en = 1;
    for (int i = 0; i < 56; i++) begin
      cfg_in = v[i];
      tick();
    end
    cfg_en = 0;
    cfg_in = 0;
  endtask
  task automatic test_reset;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      s_in = 4'($urandom);
      trigger = 6'($urandom);
      #3;
      checks++;
      if (s_out !== s_in || patch_active !== 4'b0 || cfg_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: s_out=%b pa=%b cfg_out=%b, required s_out=%b pa=0000 cfg_out=0", s_out, patch_active, cfg_out, s_in);
      end
    end
    @(negedge clk);
    rst = 1;
    trigger = '0;
    tick();
    shift('0);
    trigger = 6'h3f;
    for (int i = 0; i < 8; i++) begin
      s_in = 4'($urandom);
      #2;
      checks++;
      if (s_out !== s_in || patch_active !== 4'b0) begin
        errors++;
        $display("FAIL reset_zero_cfg: s_out=%b pa=%b, required s_out=%b pa=0000", s_out, patch_active, s_in);
      end
      tick();
    end
    trigger = '0;
  endtask
  task automatic test_level_force;
    logic [3:0] exp_pa, exp_s;
    trigger = '0;
    shift(mk('{hold: 8'd0, sel: 3'd2, action: FORCE1, en: 1'b1}, Z, Z, Z));
    for (int c = 10; c <= 15; c++) begin
      trigger = (c <= 12) ? 6'b000100 : 6'b000000;
      s_in = 4'($urandom) & 4'b1110;
      #2;
      exp_pa = (c >= 11 && c <= 13) ? 4'b0001 : 4'b0000;
      exp_s = s_in | exp_pa;
      checks++;
      if (s_out !== exp_s || patch_active !== exp_pa) begin
        errors++;
        $display("FAIL level_force c%0d: s_out=%b pa=%b, required s_out=%b pa=%b", c, s_out, patch_active, exp_s, exp_pa);
      end
      tick();
    end
    trigger = '0;
  endtask
  task automatic test_hold_invert;
    logic [3:0] exp_pa;
    shift(mk(Z, INV5, Z, Z));
    for (int c = 20; c <= 27; c++) begin
      trigger = (c == 20) ? 6'b000001 : 6'b000000;
      s_in = 4'($urandom);
      #2;
      exp_pa = (c >= 21 && c <= 25) ? 4'b0010 : 4'b0000;
      checks++;
      if (s_out !== (s_in ^ exp_pa) || patch_active !== exp_pa) begin
        errors++;
        $display("FAIL hold_invert c%0d: s_out=%b pa=%b, required s_out=%b pa=%b", c, s_out, patch_active, s_in ^ exp_pa, exp_pa);
      end
      tick();
    end
  endtask
  task automatic test_retrigger;
    logic [3:0] exp_pa;
    shift(mk(Z, INV5, Z, Z));
    for (int c = 20; c <= 30; c++) begin
      trigger = (c == 20 || c == 23) ? 6'b000001 : 6'b000000;
      s_in = 4'($urandom);
      #2;
      exp_pa = (c >= 21 && c <= 28) ? 4'b0010 : 4'b0000;
      checks++;
      if (s_out !== (s_in ^ exp_pa) || patch_active !== exp_pa) begin
        errors++;
        $display("FAIL retrigger c%0d: s_out=%b pa=%b, required s_out=%b pa=%b", c, s_out, patch_active, s_in ^ exp_pa, exp_pa);
      end
      tick();
    end
  endtask
  task automatic test_reconfig;
    logic [55:0] old_c, new_c;
    old_c = mk(Z, INV5, Z, Z);
    new_c = mk(Z, Z, '{hold: 8'd0, sel: 3'd1, action: FORCE0, en: 1'b1}, Z);
    shift(old_c);
    trigger = 6'b000001;
    tick();
    trigger = '0;
    s_in = 4'b0101;
    #2;
    checks++;
    if (patch_active !== 4'b0010 || s_out !== 4'b0111) begin
      errors++;
      $display("FAIL reconfig_pre: s_out=%b pa=%b, required s_out=0111 pa=0010", s_out, patch_active);
    end
    tick();
    for (int k = 0; k < 56; k++) begin
      cfg_en = 1;
      cfg_in = new_c[k];
      trigger = 6'h3f;
      s_in = 4'($urandom);
      #2;
      checks++;
      if (cfg_out !== old_c[k] || patch_active !== 4'b0 || s_out !== s_in) begin
        errors++;
        $display("FAIL reconfig_shift k%0d: cfg_out=%b pa=%b s_out=%b, required cfg_out=%b pa=0000 s_out=%b", k, cfg_out, patch_active, s_out, old_c[k], s_in);
      end
      tick();
    end
    cfg_en = 0;
    cfg_in = 0;
    trigger = 6'b000010;
    s_in = 4'b1111;
    #2;
    checks++;
    if (patch_active !== 4'b0 || s_out !== 4'b1111) begin
      errors++;
      $display("FAIL reconfig_first: s_out=%b pa=%b, required s_out=1111 pa=0000", s_out, patch_active);
    end
    tick();
    trigger = 6'b000001;
    #2;
    checks++;
    if (patch_active !== 4'b0100 || s_out !== 4'b1011) begin
      errors++;
      $display("FAIL reconfig_new: s_out=%b pa=%b, required s_out=1011 pa=0100", s_out, patch_active);
    end
    tick();
    trigger = '0;
    #2;
    checks++;
    if (patch_active !== 4'b0 || s_out !== 4'b1111) begin
      errors++;
      $display("FAIL reconfig_old_lane: s_out=%b pa=%b, required s_out=1111 pa=0000", s_out, patch_active);
    end
    tick();
  endtask
  task automatic test_invalid_sel;
    shift(mk('{hold: 8'd0, sel: 3'd7, action: FORCE1, en: 1'b1},
             '{hold: 8'd0, sel: 3'd5, action: FORCE0, en: 1'b0}, Z,
             '{hold: 8'd3, sel: 3'd6, action: INVERT, en: 1'b1}));
    trigger = 6'h3f;
    for (int i = 0; i < 6; i++) begin
      s_in = 4'($urandom);
      #2;
      checks++;
      if (patch_active !== 4'b0 || s_out !== s_in) begin
        errors++;
        $display("FAIL invalid_sel %0d: s_out=%b pa=%b, required s_out=%b pa=0000", i, s_out, patch_active, s_in);
      end
      tick();
    end
    trigger = '0;
  endtask
  task automatic test_async_reset;
    shift(mk(Z, INV5, Z, Z));
    trigger = 6'b000001;
    tick();
    trigger = '0;
    s_in = 4'b0110;
    #1;
    checks++;
    if (patch_active !== 4'b0010 || s_out !== 4'b0100) begin
      errors++;
      $display("FAIL areset_pre: s_out=%b pa=%b, required s_out=0100 pa=0010", s_out, patch_active);
    end
    #1;
    rst = 0;
    #1;
    checks++;
    if (patch_active !== 4'b0 || s_out !== 4'b0110) begin
      errors++;
      $display("FAIL areset_now: s_out=%b pa=%b, required s_out=0110 pa=0000", s_out, patch_active);
    end
    tick();
    rst = 1;
    trigger = 6'h3f;
    for (int i = 0; i < 4; i++) begin
      s_in = 4'($urandom);
      #2;
      checks++;
      if (patch_active !== 4'b0 || s_out !== s_in) begin
        errors++;
        $display("FAIL areset_after %0d: s_out=%b pa=%b, required s_out=%b pa=0000", i, s_out, patch_active, s_in);
      end
      tick();
    end
    trigger = '0;
    for (int k = 0; k < 56; k++) begin
      cfg_en = 1;
      cfg_in = 0;
      #2;
      checks++;
      if (cfg_out !== 1'b0) begin
        errors++;
        $display("FAIL areset_chain k%0d: cfg_out=%b, required 0", k, cfg_out);
      end
      tick();
    end
    cfg_en = 0;
  endtask
  initial begin
    test_reset();
    test_level_force();
    test_hold_invert();
    test_retrigger();
    test_reconfig();
    test_invalid_sel();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
